cpu_clk_ctrl: RTL
=================

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles needed to accept a step_btn level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 16, width of cycle_count.
REQ-003 SHALL have port clock_50MHz  input  1  sole clock; all flops on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port var_clock  input  1  divided clock from the variable clock divider; treated as a data signal, never as a clock.
REQ-006 SHALL have port run_sw  input  1  level switch: 1 = free-run, 0 = stop/single-step.
REQ-007 SHALL have port step_btn  input  1  raw, bouncy, active-high push-button.
REQ-008 SHALL have port halt_req  input  1  level halt request from the CPU (HLT executed).
REQ-009 SHALL have port cpu_en  output  1  registered one-cycle clock-enable pulse to the 12-bit CPU.
REQ-010 SHALL have port state  output  2  current FSM state, for status LEDs.
REQ-011 SHALL have port cycle_count  output  CNT_W  number of cpu_en pulses issued.

Function
REQ-012 SHALL pass var_clock through a 2-flop synchronizer, then one more flop for edge detection. tick = sync2 & ~sync3.
REQ-013 tick SHALL be high for exactly one cycle per var_clock rising edge. A var_clock rise sampled at edge N SHALL give tick high during cycle N+2.
REQ-014 SHALL synchronize step_btn with 2 flops. The debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-015 Any reversal of the synchronized input before the debounce count completes SHALL clear the debounce counter.
REQ-016 press SHALL be a one-cycle pulse on each 0->1 transition of the debounced level. A held button SHALL yield exactly one press.
REQ-017 State encodings SHALL be STOP=2'b00, RUN=2'b01, STEP=2'b10, HALT=2'b11.
REQ-018 Transition priority SHALL be halt_req, then run_sw, then press.
REQ-019 STOP: halt_req=1 -> HALT; else run_sw=1 -> RUN; else press -> STEP; else stay.
REQ-020 RUN: halt_req=1 -> HALT; else run_sw=0 -> STOP; press ignored.
REQ-021 STEP: halt_req=1 -> HALT; else tick -> STOP; press and run_sw ignored until return to STOP.
REQ-022 HALT: leave only when halt_req=0 and run_sw=0, going to STOP; press ignored.
REQ-023 cpu_en SHALL be registered and high in cycle N+1 iff tick=1 in cycle N, state is RUN or STEP, and halt_req=0 in cycle N.
REQ-024 cpu_en SHALL never be high in two consecutive cycles.
REQ-025 STEP SHALL issue exactly one cpu_en per press.
REQ-026 A tick coinciding with halt_req=1 or with the RUN->STOP transition SHALL NOT issue cpu_en.
REQ-027 cycle_count SHALL increment by 1 in the cycle after each cpu_en pulse and wrap from all-ones to 0 silently.
REQ-028 state output SHALL equal the state register (no extra latency).

Reset
REQ-029 On reset=1 at a clock edge, SHALL clear: state -> STOP, cpu_en=0, cycle_count=0, all synchronizer flops=0, debounced level=0, debounce counter=0.
REQ-030 reset SHALL override all other inputs. A pending STEP, partial debounce count, or in-flight tick SHALL be discarded without issuing cpu_en.
REQ-031 After reset deassertion, var_clock=1 SHALL NOT create a spurious tick until a genuine 0->1 transition is seen through the synchronizer.

Structure
REQ-032 Package cpu_clk_pkg SHALL hold the state encoding constants and the DEBOUNCE_CYCLES default.
REQ-033 Debounce logic SHALL be the sub-module btn_debounce (ports clock_50MHz, reset, btn_in, level, press). Synchronizer, FSM, and counter SHALL be inline.
REQ-034 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1).

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-035 run_sw=1, var_clock square wave period 10 cycles for 100 cycles -> 10 cpu_en pulses, each 1 cycle wide, 3 cycles after each var_clock rise; cycle_count=10.
REQ-036 run_sw=0, step_btn bounces 1,0,1,0 then held 1 for 20 cycles -> exactly one press, STEP, then one cpu_en on the next tick, state back to 00.
REQ-037 state RUN, halt_req=1 in the same cycle as a tick -> no cpu_en, state=11. halt_req=0 with run_sw=1 -> stays HALT. Then run_sw=0 -> STOP.
REQ-038 Preload cycle_count at 16'hFFFF via stepping, issue one pulse -> cycle_count=16'h0000, no other side effect.
REQ-039 reset asserted in STEP one cycle before a tick -> no cpu_en, state=00, cycle_count=0. var_clock held high through reset release -> no tick.

Source files
------------

// File: rtl/cpu_clk_pkg.sv
// Shared constants for the CPU clock controller: FSM state encodings and
// the default debounce length.
package cpu_clk_pkg;

  localparam logic [1:0] ST_STOP = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_STEP = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;

  // 10 ms at 50 MHz
  localparam int DEBOUNCE_DEFAULT = 500000;

  // States in which a var_clock tick is allowed to become a CPU enable.
  function automatic logic en_state(input logic [1:0] st, input logic run_sw);
    return ((st == ST_RUN) && run_sw) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// Step push-button conditioner: 2-flop synchronizer, consecutive-cycle
// debounce of the level, and a one-cycle pulse on each accepted press.
module btn_debounce
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clock_50MHz,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn_in};
      press <= 1'b0;
      // any cycle where the input agrees with the accepted level restarts the count
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == TC) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: turns the variable divider clock into single-cycle
// enables for the CPU, with free-run, single-step and halt modes.
//
// state | meaning
// STOP  | idle, waiting for run_sw or a step press
// RUN   | every var_clock tick issues cpu_en
// STEP  | next var_clock tick issues one cpu_en, then back to STOP
// HALT  | CPU executed HLT; wait for halt_req=0 and run_sw=0
module cpu_clk_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 16
) (
  input  logic             clock_50MHz,
  input  logic             reset,
  input  logic             var_clock,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_count
);

  logic [2:0] vc_sync;
  logic [2:0] vc_vld;
  logic       tick;
  logic       btn_level;
  logic       press_raw;
  logic       btn_press;
  logic [1:0] state_q;
  logic [1:0] state_nxt;
  logic       en_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clock_50MHz(clock_50MHz),
    .reset      (reset),
    .btn_in     (step_btn),
    .level      (btn_level),
    .press      (press_raw)
  );

  assign btn_press = press_raw & btn_level;

  // vc_vld marks which synchronizer stages hold post-reset samples, so a
  // var_clock held high through reset cannot fake a rising edge.
  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      vc_sync <= 3'b000;
      vc_vld  <= 3'b000;
    end else begin
      vc_sync <= {vc_sync[1:0], var_clock};
      vc_vld  <= {vc_vld[1:0], 1'b1};
    end
  end

  assign tick = vc_sync[1] & ~vc_sync[2] & vc_vld[2];

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_STOP: begin
        if (halt_req)       state_nxt = ST_HALT;
        else if (run_sw)    state_nxt = ST_RUN;
        else if (btn_press) state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (halt_req)       state_nxt = ST_HALT;
        else if (!run_sw)   state_nxt = ST_STOP;
      end
      ST_STEP: begin
        if (halt_req)       state_nxt = ST_HALT;
        else if (tick)      state_nxt = ST_STOP;
      end
      default: begin
        if (!halt_req && !run_sw) state_nxt = ST_STOP;
      end
    endcase
  end

  // a tick on the RUN->STOP cycle is dropped, hence run_sw in en_state
  assign en_nxt = tick & ~halt_req & en_state(state_q, run_sw);

  always_ff @(posedge clock_50MHz) begin
    if (reset) begin
      state_q     <= ST_STOP;
      cpu_en      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state_q <= state_nxt;
      cpu_en  <= en_nxt;
      if (cpu_en) cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule
